// File: rtl/spi_flash_sequencer_if.sv
// spi_flash_sequencer_if: host command/response and byte-engine signals of the flash sequencer.
interface spi_flash_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        eng_cs_n;
  logic        eng_start;
  logic [7:0]  eng_tx;
  logic        eng_done;
  logic [7:0]  eng_rx;
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, eng_done, eng_rx,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, eng_cs_n, eng_start, eng_tx
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, eng_done, eng_rx,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, eng_cs_n, eng_start, eng_tx
  );
endinterface

// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer: turns read/program/erase commands into SPI flash byte frames with status polling.
module spi_flash_sequencer #(
  parameter int POLL_MAX = 1023,
  parameter int GAP_CYC  = 2
) (
  input logic p_clk,
  input logic p_reset_n,
  spi_flash_sequencer_if.slave bus
);
  localparam int PW = $clog2(POLL_MAX + 1) < 10 ? 10 : $clog2(POLL_MAX + 1);
  typedef enum logic [1:0] {IDLE, FRAME, GAP, RESP} state_t;
  typedef enum logic [1:0] {WREN, MAIN, POLL} phase_t;
  state_t state, nxt;
  phase_t phase;
  logic [1:0] op;
  logic [23:0] addr;
  logic [31:0] wdata, rdata;
  logic [2:0] idx;
  logic busy, armed, err;
  logic [PW-1:0] pcnt;
  logic [7:0] gcnt;
  logic accept, done, last, gap_end, poll_to;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign done = bus.eng_done && busy && state == FRAME;
  assign last = idx == (phase == WREN ? 3'd0 : phase == POLL ? 3'd1 : op == 2'b10 ? 3'd3 : 3'd7);
  assign gap_end = gcnt == 8'(GAP_CYC - 1);
  assign poll_to = pcnt + 1'b1 == PW'(POLL_MAX);
  always_ff @(posedge p_clk or negedge p_reset_n)
    if (!p_reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (accept) nxt = bus.cmd_op == 2'b11 ? RESP : FRAME;
      FRAME: if (done && last)
               nxt = (phase == MAIN && op == 2'b00) || (phase == POLL && (!bus.eng_rx[0] || poll_to)) ? RESP : GAP;
      GAP:   if (gap_end) nxt = FRAME;
      RESP:  if (bus.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // first FRAME cycle only drops chip select; bytes start once armed
  always_comb begin
    bus.cmd_ready = state == IDLE && p_reset_n;
    bus.rsp_valid = state == RESP;
    bus.rsp_rdata = rdata;
    bus.rsp_err = err;
    bus.eng_cs_n = state != FRAME;
    bus.eng_start = state == FRAME && armed && !busy;
    bus.eng_tx = !bus.eng_start ? 8'h00 :
                 phase == WREN ? 8'h06 :
                 phase == POLL ? (idx == 3'd0 ? 8'h05 : 8'h00) :
                 idx == 3'd0 ? (op == 2'b00 ? 8'h03 : op == 2'b01 ? 8'h02 : 8'h20) :
                 idx == 3'd1 ? addr[23:16] :
                 idx == 3'd2 ? addr[15:8] :
                 idx == 3'd3 ? addr[7:0] :
                 op == 2'b01 ? wdata[{2'd3 - idx[1:0], 3'd0} +: 8] : 8'h00;
  end
  always_ff @(posedge p_clk or negedge p_reset_n)
    if (!p_reset_n) begin
      phase <= WREN;
      op <= '0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      err <= 1'b0;
      idx <= '0;
      busy <= 1'b0;
      armed <= 1'b0;
      pcnt <= '0;
      gcnt <= '0;
    end else begin
      armed <= state == FRAME;
      gcnt <= state == GAP ? gcnt + 1'b1 : 8'd0;
      if (bus.eng_start) busy <= 1'b1;
      if (done) begin
        busy <= 1'b0;
        idx <= last ? 3'd0 : idx + 1'b1;
        if (phase == MAIN && op == 2'b00 && idx[2]) rdata <= {rdata[23:0], bus.eng_rx};
        if (last) phase <= phase == WREN ? MAIN : POLL;
        if (last && phase == POLL) pcnt <= pcnt + 1'b1;
        if (last && phase == POLL && bus.eng_rx[0] && poll_to) err <= 1'b1;
      end
      if (accept) begin
        op <= bus.cmd_op;
        addr <= bus.cmd_addr;
        wdata <= bus.cmd_wdata;
        phase <= bus.cmd_op == 2'b00 ? MAIN : WREN;
        rdata <= '0;
        err <= bus.cmd_op == 2'b11;
        idx <= '0;
        pcnt <= '0;
      end
    end
endmodule

// File: tb/tb_spi_flash_sequencer.sv
// tb_spi_flash_sequencer: directed bench with a byte-engine model and frame/gap timing monitor.
module tb_spi_flash_sequencer;
  logic p_clk = 1'b0;
  logic p_reset_n = 1'b0;
  always #5 p_clk = ~p_clk;
  spi_flash_sequencer_if bus();
  spi_flash_sequencer #(.POLL_MAX(4), .GAP_CYC(2)) dut (.p_clk(p_clk), .p_reset_n(p_reset_n), .bus(bus));
  int nvec = 0;
  int nerr = 0;
  logic [8:0] log_q[$];
  logic [7:0] rxq[$];
  logic [7:0] rx_dflt = 8'h00;
  int gaps[$];
  int frames = 0;
  int tviol = 0;
  logic inject = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // engine answers each byte two cycles after eng_start; monitor logs frames (9'h100 marks cs_n fall)
  initial begin
    int cnt = 0;
    int hi_run = 0;
    logic prev_cs = 1'b1, prev_done = 1'b0, prev_rst = 1'b0, fell = 1'b0, d;
    logic [7:0] rv;
    bus.eng_done = 1'b0;
    bus.eng_rx = 8'h00;
    forever begin
      @(negedge p_clk);
      if (bus.eng_start && (prev_cs || bus.eng_cs_n)) tviol++;
      if (fell && !bus.eng_start) tviol++;
      if (!prev_cs && bus.eng_cs_n && prev_rst && p_reset_n && !prev_done) tviol++;
      fell = prev_cs && !bus.eng_cs_n;
      if (fell) begin
        if (frames > 0) gaps.push_back(hi_run);
        frames++;
        log_q.push_back(9'h100);
      end
      hi_run = bus.eng_cs_n ? hi_run + 1 : 0;
      d = 1'b0;
      rv = 8'h00;
      if (!p_reset_n) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          d = 1'b1;
          rv = rxq.size() > 0 ? rxq.pop_front() : rx_dflt;
        end
      end
      if (bus.eng_start) begin
        log_q.push_back({1'b0, bus.eng_tx});
        cnt = 2;
      end
      if (inject) begin
        d = 1'b1;
        rv = 8'h01;
        inject = 1'b0;
      end
      bus.eng_done = d;
      bus.eng_rx = rv;
      prev_cs = bus.eng_cs_n;
      prev_done = d;
      prev_rst = p_reset_n;
    end
  end
  task automatic send(input logic [1:0] op, input logic [23:0] a, input logic [31:0] wd);
    int n = 0;
    log_q.delete();
    gaps.delete();
    frames = 0;
    tviol = 0;
    @(negedge p_clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_addr = a;
    bus.cmd_wdata = wd;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge p_clk);
      n++;
    end
    chk("cmd_accept", 32'(n < 50), 1);
    @(negedge p_clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp(input int hold, output logic [31:0] rd, output logic er, output int n);
    int bad = 0;
    n = 0;
    while (!bus.rsp_valid && n < 2000) begin
      @(negedge p_clk);
      n++;
    end
    chk("rsp_timeout", 32'(n < 2000), 1);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    repeat (hold) begin
      @(negedge p_clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rd || bus.rsp_err !== er || bus.cmd_ready !== 1'b0) bad++;
    end
    if (hold > 0) chk("rsp_hold_stable", 32'(bad), 0);
    bus.rsp_ready = 1'b1;
    @(negedge p_clk);
    bus.rsp_ready = 1'b0;
  endtask
  task automatic cmp_log(input string tag, input logic [8:0] e[$]);
    chk({tag, "_len"}, 32'(log_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < log_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(log_q[i]), 32'(e[i]));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    logic er;
    int n, bad;
    logic [8:0] e[$];
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_addr = 24'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge p_clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst_cs_n", 32'(bus.eng_cs_n), 1);
    chk("rst_start", 32'(bus.eng_start), 0);
    chk("rst_tx", 32'(bus.eng_tx), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    #3 p_reset_n = 1'b1;
    @(negedge p_clk);
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 1);
    // read 0x123456
    rxq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(2'b00, 24'h123456, 32'h0);
    wait_rsp(0, rd, er, n);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 0);
    e = '{9'h100, 9'h003, 9'h012, 9'h034, 9'h056, 9'h000, 9'h000, 9'h000, 9'h000};
    cmp_log("rd", e);
    chk("rd_timing", 32'(tviol), 0);
    // program with two busy polls
    rxq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00};
    send(2'b01, 24'h000100, 32'hA5A55A5A);
    wait_rsp(0, rd, er, n);
    chk("pg_err", 32'(er), 0);
    chk("pg_rdata", rd, 0);
    e = '{9'h100, 9'h006, 9'h100, 9'h002, 9'h000, 9'h001, 9'h000, 9'h0A5, 9'h0A5, 9'h05A, 9'h05A,
          9'h100, 9'h005, 9'h000, 9'h100, 9'h005, 9'h000, 9'h100, 9'h005, 9'h000};
    cmp_log("pg", e);
    chk("pg_ngaps", 32'(gaps.size()), 4);
    foreach (gaps[i]) chk($sformatf("pg_gap%0d", i), 32'(gaps[i]), 2);
    chk("pg_timing", 32'(tviol), 0);
    // erase with status stuck busy -> timeout after POLL_MAX=4 polls
    rxq.delete();
    rx_dflt = 8'h01;
    send(2'b10, 24'hAABBCC, 32'h0);
    wait_rsp(0, rd, er, n);
    rx_dflt = 8'h00;
    chk("er_err", 32'(er), 1);
    chk("er_rdata", rd, 0);
    chk("er_frames", 32'(frames), 6);
    e = '{9'h100, 9'h006, 9'h100, 9'h020, 9'h0AA, 9'h0BB, 9'h0CC,
          9'h100, 9'h005, 9'h000, 9'h100, 9'h005, 9'h000, 9'h100, 9'h005, 9'h000, 9'h100, 9'h005, 9'h000};
    cmp_log("er", e);
    chk("er_timing", 32'(tviol), 0);
    // illegal op
    send(2'b11, 24'h0, 32'h0);
    wait_rsp(0, rd, er, n);
    chk("ill_latency", 32'(n <= 1), 1);
    chk("ill_err", 32'(er), 1);
    chk("ill_rdata", rd, 0);
    chk("ill_frames", 32'(frames), 0);
    chk("ill_bytes", 32'(log_q.size()), 0);
    // response backpressure
    rxq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send(2'b00, 24'hABCDEF, 32'h0);
    wait_rsp(10, rd, er, n);
    chk("bp_rdata", rd, 32'h11223344);
    chk("bp_err", 32'(er), 0);
    // spurious eng_done while idle
    log_q.delete();
    frames = 0;
    @(negedge p_clk);
    inject = 1'b1;
    repeat (6) @(negedge p_clk);
    chk("spur_bytes", 32'(log_q.size()), 0);
    chk("spur_frames", 32'(frames), 0);
    chk("spur_ready", 32'(bus.cmd_ready), 1);
    // reset during address byte 2 of a program
    rxq.delete();
    send(2'b01, 24'h345678, 32'h01020304);
    n = 0;
    while (log_q.size() < 6 && n < 200) begin
      @(negedge p_clk);
      n++;
    end
    chk("rst_reach_addr2", 32'(n < 200), 1);
    #3 p_reset_n = 1'b0;
    #1;
    chk("arst_cs_n", 32'(bus.eng_cs_n), 1);
    chk("arst_start", 32'(bus.eng_start), 0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 0);
    repeat (3) @(negedge p_clk);
    #3 p_reset_n = 1'b1;
    @(negedge p_clk);
    chk("arst_rel_ready", 32'(bus.cmd_ready), 1);
    bad = 0;
    repeat (20) begin
      @(negedge p_clk);
      if (bus.rsp_valid) bad++;
    end
    chk("arst_no_rsp", 32'(bad), 0);
    rxq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send(2'b00, 24'h000010, 32'h0);
    wait_rsp(0, rd, er, n);
    chk("post_rd_rdata", rd, 32'hCAFEBABE);
    chk("post_rd_err", 32'(er), 0);
    e = '{9'h100, 9'h003, 9'h000, 9'h000, 9'h010, 9'h000, 9'h000, 9'h000, 9'h000};
    cmp_log("post_rd", e);
    chk("post_rd_timing", 32'(tviol), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/spi_flash_sequencer.md
SPI_FLASH_SEQUENCER -- requirements
Module: spi_flash_sequencer

Interface
REQ-001 SHALL provide parameter POLL_MAX, default 1023, maximum number of status-register polls before timeout.
REQ-002 SHALL provide parameter GAP_CYC, default 2, minimum p_clk cycles eng_cs_n stays high between frames.
REQ-003 p_clk  in  1  single clock; all logic on rising edge.
REQ-004 p_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  in  1  host command request.
REQ-006 cmd_ready  out  1  sequencer can accept a command.
REQ-007 cmd_op  in  2  00 read, 01 program, 10 sector erase, 11 illegal.
REQ-008 cmd_addr  in  24  flash byte address.
REQ-009 cmd_wdata  in  32  program data, sent MSB byte first.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  host accepts response.
REQ-012 rsp_rdata  out  32  read data, first received byte in [31:24].
REQ-013 rsp_err  out  1  illegal op or poll timeout.
REQ-014 eng_cs_n  out  1  flash chip select to byte engine, low during a frame.
REQ-015 eng_start  out  1  one-cycle pulse launching one byte transfer.
REQ-016 eng_tx  out  8  byte to shift out, valid with eng_start.
REQ-017 eng_done  in  1  one-cycle pulse, byte transfer complete.
REQ-018 eng_rx  in  8  byte shifted in, valid with eng_done.

Function
REQ-019 States SHALL be IDLE, FRAME, GAP, RESP; FRAME runs a byte list selected by a phase register (WREN, MAIN, POLL).
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready, latching cmd_op/addr/wdata.
REQ-021 Read: single MAIN frame 0x03, A[23:16], A[15:8], A[7:0], then four bytes with eng_tx=0x00; eng_rx captured MSB first into rsp_rdata.
REQ-022 Program: WREN frame (0x06), GAP, MAIN frame 0x02, three address bytes, four data bytes, GAP, then POLL.
REQ-023 Erase: WREN frame (0x06), GAP, MAIN frame 0x20 plus three address bytes, GAP, then POLL.
REQ-024 POLL frame SHALL be 0x05 then one byte with eng_tx=0x00; if eng_rx[0]=1 and poll count < POLL_MAX, GAP and repeat; if eng_rx[0]=0 go RESP with rsp_err=0; if count reaches POLL_MAX go RESP with rsp_err=1.
REQ-025 Poll counter SHALL be 10 bits wide minimum (clog2(POLL_MAX+1)), cleared at each accepted command, no wrap.
REQ-026 eng_cs_n SHALL fall one cycle before the first eng_start of a frame and rise the cycle after the last eng_done of the frame.
REQ-027 Exactly one eng_start per byte; next eng_start no earlier than the cycle after the previous eng_done.
REQ-028 eng_done arriving while no byte is outstanding SHALL be ignored.
REQ-029 GAP SHALL hold eng_cs_n high exactly GAP_CYC cycles.
REQ-030 Illegal op (11): SHALL go directly to RESP with rsp_err=1, rsp_rdata=0, no eng_cs_n activity.
REQ-031 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid & rsp_ready, then IDLE next cycle.
REQ-032 For program/erase responses rsp_rdata SHALL be 0.
REQ-033 A new command SHALL NOT be accepted in the same cycle a response is accepted.

Reset
REQ-034 On p_reset_n low, immediately: state IDLE, eng_cs_n=1, eng_start=0, eng_tx=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, cmd_ready=0 while reset held, counters 0.
REQ-035 Reset mid-frame SHALL abort the operation with no response; cmd_ready=1 the first cycle after release.

Verification
REQ-036 Read 0x123456, engine returns DE AD BE EF -> tx bytes 03 12 34 56 00 00 00 00 in one frame, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Program 0x000100 data 0xA5A55A5A, status returns 01,01,00 -> frames 06 | 02 00 01 00 A5 A5 5A 5A | 05 00 x3, each gap exactly 2 cycles, rsp_err=0.
REQ-038 Erase with status stuck 01, POLL_MAX=4 -> exactly 4 poll frames, rsp_err=1.
REQ-039 cmd_op=11 -> rsp_valid within 2 cycles, rsp_err=1, eng_cs_n never low.
REQ-040 Assert reset during address byte 2 of a program -> eng_cs_n=1 asynchronously, no response, next read completes correctly.
REQ-041 Hold rsp_ready=0 for 10 cycles -> rsp outputs stable, cmd_ready=0 throughout; spurious eng_done in IDLE has no effect.
